// File: rtl/usr_seq.sv
// usr_seq: universal shift register with a command/handshake front end.
// A command either acts in a single cycle (NOP, LOAD, CLEAR, zero-count
// shift) or starts a multi-step shift that advances one bit per clock
// until its count is exhausted, then pulses done.
module usr_seq #(
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    amt,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  // Operation codes.
  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_SHR   = 3'b001;
  localparam logic [2:0] OP_SHL   = 3'b010;
  localparam logic [2:0] OP_ROR   = 3'b011;
  localparam logic [2:0] OP_ROL   = 3'b100;
  localparam logic [2:0] OP_ASR   = 3'b101;
  localparam logic [2:0] OP_LOAD  = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  // Sequencer states.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Largest meaningful step count; AW is wide enough to hold WIDTH itself.
  localparam logic [AW-1:0] AMT_MAX = AW'(WIDTH);
  localparam logic [AW-1:0] AMT_ONE = AW'(1);

  // Architectural and sequencer state.
  logic [0:0]       state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             ser_out_q, ser_out_d;
  logic             done_q, done_d;

  // Command decode.
  logic             idle;
  logic             is_shift;
  logic [AW-1:0]    eff_amt;

  // Single-step datapath for the latched operation.
  logic             dir_right;
  logic             right_fill;
  logic             left_fill;
  logic [WIDTH-1:0] right_shift;
  logic [WIDTH-1:0] left_shift;
  logic [WIDTH-1:0] step_q;
  logic             step_so;

  assign idle = (state_q == ST_IDLE);

  // Decode the incoming command: shift class and clamped step count.
  always_comb begin
    is_shift = (op >= OP_SHR) && (op <= OP_ASR);
    eff_amt  = (amt > AMT_MAX) ? AMT_MAX : amt;
  end

  // Bit shifted in at the MSB (right-moving ops) or LSB (left-moving ops).
  always_comb begin
    dir_right  = (op_q == OP_SHR) || (op_q == OP_ROR) || (op_q == OP_ASR);
    right_fill = q_q[WIDTH-1];
    left_fill  = q_q[WIDTH-1];
    case (op_q)
      OP_SHR:  right_fill = ser_in;
      OP_ROR:  right_fill = q_q[0];
      default: right_fill = q_q[WIDTH-1];
    endcase
    case (op_q)
      OP_SHL:  left_fill = ser_in;
      default: left_fill = q_q[WIDTH-1];
    endcase
  end

  // Per-bit neighbour selection: each bit takes its upper neighbour when
  // moving right and its lower neighbour when moving left; the end bits
  // take the fill bit instead.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi == WIDTH - 1) begin : g_msb
        assign right_shift[gi] = right_fill;
      end else begin : g_rmid
        assign right_shift[gi] = q_q[gi+1];
      end
      if (gi == 0) begin : g_lsb
        assign left_shift[gi] = left_fill;
      end else begin : g_lmid
        assign left_shift[gi] = q_q[gi-1];
      end
    end
  endgenerate

  // Result of one step and the bit that leaves the register.
  always_comb begin
    step_q  = dir_right ? right_shift : left_shift;
    step_so = dir_right ? q_q[0] : q_q[WIDTH-1];
  end

  // Sequencer next state: accept in IDLE, one step per clock in RUN.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    q_d       = q_q;
    ser_out_d = ser_out_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (is_shift && (eff_amt != '0)) begin
            // Register contents untouched at the accept edge; steps follow.
            op_d    = op;
            cnt_d   = eff_amt;
            state_d = ST_RUN;
          end else begin
            case (op)
              OP_LOAD:  q_d = d;
              OP_CLEAR: q_d = '0;
              default:  q_d = q_q;
            endcase
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // Inputs other than ser_in are ignored while a shift is running.
        q_d       = step_q;
        ser_out_d = step_so;
        cnt_d     = cnt_q - AMT_ONE;
        if (cnt_q == AMT_ONE) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous reset; reset also aborts a running shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_NOP;
      q_q       <= '0;
      ser_out_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      q_q       <= q_d;
      ser_out_q <= ser_out_d;
      done_q    <= done_d;
    end
  end

  assign q         = q_q;
  assign ser_out   = ser_out_q;
  assign busy      = ~idle;
  assign cmd_ready = idle;
  assign done      = done_q;

endmodule

// File: tb/tb_usr_seq.sv
// tb_usr_seq: drives one shared command stream into WIDTH=4, 8 and 16
// instances and checks every cycle against a cycle-indexed reference model,
// plus literal expectations on the 8-bit instance for the directed scenarios.
module tb_usr_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [2:0]  op;
  logic [4:0]  amt;
  logic [15:0] d;
  logic        ser_in;

  logic [3:0]  q4;
  logic [7:0]  q8;
  logic [15:0] q16;
  logic        rdy4, rdy8, rdy16;
  logic        so4, so8, so16;
  logic        bsy4, bsy8, bsy16;
  logic        dn4, dn8, dn16;

  always #5 clk = ~clk;

  usr_seq #(.WIDTH(4)) u_w4 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy4),
    .op(op), .amt(amt[2:0]), .d(d[3:0]), .ser_in(ser_in),
    .q(q4), .ser_out(so4), .busy(bsy4), .done(dn4));

  usr_seq #(.WIDTH(8)) u_w8 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy8),
    .op(op), .amt(amt[3:0]), .d(d[7:0]), .ser_in(ser_in),
    .q(q8), .ser_out(so8), .busy(bsy8), .done(dn8));

  usr_seq #(.WIDTH(16)) u_w16 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy16),
    .op(op), .amt(amt[4:0]), .d(d[15:0]), .ser_in(ser_in),
    .q(q16), .ser_out(so16), .busy(bsy16), .done(dn16));

  logic [15:0] dq[3];
  logic        dso[3], dbsy[3], ddn[3], drdy[3];
  assign dq[0] = {12'b0, q4};
  assign dq[1] = {8'b0, q8};
  assign dq[2] = q16;
  assign dso[0] = so4;   assign dso[1] = so8;   assign dso[2] = so16;
  assign dbsy[0] = bsy4; assign dbsy[1] = bsy8; assign dbsy[2] = bsy16;
  assign ddn[0] = dn4;   assign ddn[1] = dn8;   assign ddn[2] = dn16;
  assign drdy[0] = rdy4; assign drdy[1] = rdy8; assign drdy[2] = rdy16;

  // ---------------- reference model ----------------
  int          wv[3]  = '{4, 8, 16};
  int          awv[3] = '{3, 4, 5};
  logic [15:0] m_q[3];
  logic        m_so[3];
  logic        m_done[3];
  logic [2:0]  m_op[3];
  int          m_end[3];   // edge index of the last step of a running shift
  int          cyc;        // number of rising edges seen so far
  bit          rst_seen;

  int checks = 0;
  int errors = 0;

  // One step of op o on a w-bit value v, written as plain arithmetic.
  function automatic logic [15:0] mstep(int w, logic [2:0] o, logic [15:0] v,
                                        logic si, output logic so);
    logic [15:0] mask;
    logic        msb;
    logic        lsb;
    mask = 16'((32'd1 << w) - 32'd1);
    msb  = v[w-1];
    lsb  = v[0];
    case (o)
      3'd1: begin so = lsb; return ((v >> 1) | (16'(si) << (w - 1))) & mask; end
      3'd2: begin so = msb; return ((v << 1) | 16'(si)) & mask; end
      3'd3: begin so = lsb; return ((v >> 1) | (16'(lsb) << (w - 1))) & mask; end
      3'd4: begin so = msb; return ((v << 1) | 16'(msb)) & mask; end
      3'd5: begin so = lsb; return ((v >> 1) | (16'(msb) << (w - 1))) & mask; end
      default: begin so = 1'b0; return v; end
    endcase
  endfunction

  task automatic model_edge(int i);
    int          w;
    int          a;
    int          n;
    logic        so;
    logic [15:0] mask;
    w    = wv[i];
    mask = 16'((32'd1 << w) - 32'd1);
    if (reset) begin
      m_q[i] = '0; m_so[i] = 1'b0; m_done[i] = 1'b0; m_end[i] = cyc;
    end else if (cyc <= m_end[i]) begin
      m_q[i]    = mstep(w, m_op[i], m_q[i], ser_in, so);
      m_so[i]   = so;
      m_done[i] = (cyc == m_end[i]);
    end else begin
      m_done[i] = 1'b0;
      if (cmd_valid) begin
        a = int'(amt) & ((1 << awv[i]) - 1);
        n = (a > w) ? w : a;
        if (op >= 3'd1 && op <= 3'd5 && n > 0) begin
          m_op[i]  = op;
          m_end[i] = cyc + n;
        end else begin
          if (op == 3'd6) m_q[i] = d & mask;
          if (op == 3'd7) m_q[i] = '0;
          m_done[i] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    cyc = 0;
    rst_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_q[i] = '0; m_so[i] = 1'b0; m_done[i] = 1'b0; m_op[i] = '0; m_end[i] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) rst_seen = 1'b1;
      for (int i = 0; i < 3; i++) model_edge(i);
    end
  end

  // ---------------- literal expectations (8-bit instance) ----------------
  typedef struct {
    int         at;
    bit         ck_q;
    logic [7:0] q;
    bit         ck_so;
    logic       so;
    logic       bsy;
    logic       dn;
  } lit_t;
  lit_t lq[$];

  task automatic expect8(int at, bit ckq, logic [7:0] qv, bit ckso, logic sov,
                         logic b, logic dn_v);
    lit_t l;
    l.at = at; l.ck_q = ckq; l.q = qv; l.ck_so = ckso; l.so = sov;
    l.bsy = b; l.dn = dn_v;
    lq.push_back(l);
  endtask

  // ---------------- compare process ----------------
  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("q_w%0d", wv[i]), dq[i], m_q[i]);
          chk($sformatf("ser_out_w%0d", wv[i]), 16'(dso[i]), 16'(m_so[i]));
          chk($sformatf("busy_w%0d", wv[i]), 16'(dbsy[i]), 16'(cyc < m_end[i]));
          chk($sformatf("done_w%0d", wv[i]), 16'(ddn[i]), 16'(m_done[i]));
          chk($sformatf("ready_w%0d", wv[i]), 16'(drdy[i]), 16'(!(cyc < m_end[i])));
        end
      end
      while (lq.size() > 0 && lq[0].at <= cyc) begin
        chk("lit_sched", 16'(lq[0].at), 16'(cyc));
        if (lq[0].ck_q)  chk("lit_q8", 16'(q8), 16'(lq[0].q));
        if (lq[0].ck_so) chk("lit_so8", 16'(so8), 16'(lq[0].so));
        chk("lit_busy8", 16'(bsy8), 16'(lq[0].bsy));
        chk("lit_done8", 16'(dn8), 16'(lq[0].dn));
        void'(lq.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(logic [2:0] o, logic [4:0] a, logic [15:0] dv, logic si,
                       output int c);
    @(negedge clk);
    cmd_valid = 1'b1; op = o; amt = a; d = dv; ser_in = si;
    c = cyc;
  endtask

  task automatic wait_idle();
    int k;
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 0;
    while (!(rdy4 && rdy8 && rdy16)) begin
      @(negedge clk);
      k++;
      if (k > 100) begin
        $display("FAIL wait_idle timeout cyc=%0d", cyc);
        $fatal(1, "wait_idle timeout");
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int c;
    reset = 1'b1; cmd_valid = 1'b0; op = '0; amt = '0; d = '0; ser_in = 1'b0;
    repeat (2) @(negedge clk);
    expect8(cyc + 1, 1, 8'h00, 1, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // LOAD 0x96
    issue(3'd6, 5'd0, 16'h0096, 1'b0, c);
    expect8(c + 1, 1, 8'h96, 1, 1'b0, 1'b0, 1'b1);
    expect8(c + 2, 1, 8'h96, 1, 1'b0, 1'b0, 1'b0);
    wait_idle();

    // SHR 3 with ser_in=1
    issue(3'd1, 5'd3, 16'h0000, 1'b1, c);
    expect8(c + 1, 1, 8'h96, 1, 1'b0, 1'b1, 1'b0);
    expect8(c + 2, 1, 8'hCB, 1, 1'b0, 1'b1, 1'b0);
    expect8(c + 3, 1, 8'hE5, 1, 1'b1, 1'b1, 1'b0);
    expect8(c + 4, 1, 8'hF2, 1, 1'b1, 1'b0, 1'b1);
    wait_idle();

    // LOAD 0x96, ASR 2, ROL 8, ROR 12
    issue(3'd6, 5'd0, 16'h9696, 1'b0, c);
    expect8(c + 1, 1, 8'h96, 0, 1'b0, 1'b0, 1'b1);
    wait_idle();
    issue(3'd5, 5'd2, 16'h0000, 1'b0, c);
    expect8(c + 2, 1, 8'hCB, 0, 1'b0, 1'b1, 1'b0);
    expect8(c + 3, 1, 8'hE5, 0, 1'b0, 1'b0, 1'b1);
    wait_idle();
    issue(3'd4, 5'd8, 16'h0000, 1'b0, c);
    expect8(c + 8, 0, 8'h00, 0, 1'b0, 1'b1, 1'b0);
    expect8(c + 9, 1, 8'hE5, 0, 1'b0, 1'b0, 1'b1);
    wait_idle();
    issue(3'd3, 5'd12, 16'h0000, 1'b0, c);
    expect8(c + 8, 0, 8'h00, 0, 1'b0, 1'b1, 1'b0);
    expect8(c + 9, 1, 8'hE5, 0, 1'b0, 1'b0, 1'b1);
    wait_idle();

    // SHL 5 with a LOAD 0xFF held during the run, then SHL 0
    issue(3'd2, 5'd5, 16'h0000, 1'b0, c);
    expect8(c + 5, 0, 8'h00, 0, 1'b0, 1'b1, 1'b0);
    expect8(c + 6, 1, 8'hA0, 0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    op = 3'd6; d = 16'hFFFF;
    repeat (4) @(negedge clk);
    wait_idle();
    issue(3'd6, 5'd0, 16'h00A0, 1'b0, c);
    wait_idle();
    issue(3'd2, 5'd0, 16'h0000, 1'b1, c);
    expect8(c + 1, 1, 8'hA0, 0, 1'b0, 1'b0, 1'b1);
    wait_idle();

    // SHR 5 aborted by reset at E2, then LOAD right after
    issue(3'd6, 5'd0, 16'h0096, 1'b0, c);
    wait_idle();
    issue(3'd1, 5'd5, 16'h0000, 1'b1, c);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    expect8(cyc + 1, 1, 8'h00, 1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0; cmd_valid = 1'b1; op = 3'd6; d = 16'h005A;
    expect8(cyc + 1, 1, 8'h5A, 1, 1'b0, 1'b0, 1'b1);
    wait_idle();

    // Randomized traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      reset     = ($urandom_range(0, 199) == 0);
      cmd_valid = ($urandom_range(0, 2) != 0);
      op        = 3'($urandom);
      amt       = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      d         = 16'($urandom);
      ser_in    = 1'($urandom);
    end
    @(negedge clk);
    reset = 1'b0; cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
